// File: rtl/proc_control_fsm.sv
// Control sequencer for the nine-bit processor: fetches IR from DIN and steps T0..T3.
// Define CTRL_MVNZ_EN to add the conditional-move opcode (100 = mvnz Rx,Ry).
module proc_control_fsm #(
    parameter bit ILLEGAL_DONE = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [8:0] DIN,
    input  logic       g_nonzero,
    output logic [7:0] r_out,
    output logic       g_out,
    output logic       DIN_out,
    output logic [7:0] r_in,
    output logic       a_load,
    output logic       g_load,
    output logic       add_sub,
    output logic       done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef CTRL_MVNZ_EN
    localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

    state_t     state;
    logic [8:0] ir;
    logic [2:0] opcode;
    logic [7:0] x_sel;
    logic [7:0] y_sel;

    assign opcode = ir[8:6];
    assign x_sel  = 8'b1 << ir[5:3];
    assign y_sel  = 8'b1 << ir[2:0];

`ifndef CTRL_MVNZ_EN
    logic unused_g_nonzero;
    assign unused_g_nonzero = g_nonzero;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: begin
                    if (run) begin
                        ir    <= DIN;
                        state <= T1;
                    end
                end
                T1: begin
                    if (opcode == OP_ADD || opcode == OP_SUB)
                        state <= T2;
                    else
                        state <= T0;
                end
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Outputs decode straight from state+IR so mvi/mvnz can act on DIN and
    // g_nonzero in the same cycle; reset masks everything to avoid partial writes.
    always_comb begin
        r_out   = '0;
        g_out   = 1'b0;
        DIN_out = 1'b0;
        r_in    = '0;
        a_load  = 1'b0;
        g_load  = 1'b0;
        add_sub = 1'b0;
        done    = 1'b0;
        if (!reset) begin
            case (state)
                T1: begin
                    case (opcode)
                        OP_MV: begin
                            r_out = y_sel;
                            r_in  = x_sel;
                            done  = 1'b1;
                        end
                        OP_MVI: begin
                            DIN_out = 1'b1;
                            r_in    = x_sel;
                            done    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            r_out  = x_sel;
                            a_load = 1'b1;
                        end
`ifdef CTRL_MVNZ_EN
                        OP_MVNZ: begin
                            if (g_nonzero) begin
                                r_out = y_sel;
                                r_in  = x_sel;
                            end
                            done = 1'b1;
                        end
`endif
                        default: done = ILLEGAL_DONE;
                    endcase
                end
                T2: begin
                    r_out   = y_sel;
                    g_load  = 1'b1;
                    add_sub = (opcode == OP_SUB);
                end
                T3: begin
                    g_out = 1'b1;
                    r_in  = x_sel;
                    done  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Table-driven scoreboard bench for proc_control_fsm; a second instance
// runs with ILLEGAL_DONE=0 to cover the silent-illegal variant.
module tb_proc_control_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [8:0] DIN = '0;
    logic       g_nonzero = 1'b0;

    logic [7:0] r_out, r_in, q_r_out, q_r_in;
    logic g_out, DIN_out, a_load, g_load, add_sub, done;
    logic q_g_out, q_DIN_out, q_a_load, q_g_load, q_add_sub, q_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       run;
        logic [8:0] din;
        logic       gnz;
        logic [22:0] exp;
        logic       illegal;
        string      name;
    } vec_t;

    typedef struct {
        logic [22:0] exp_main;
        logic [22:0] exp_quiet;
        string       name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    proc_control_fsm #(.ILLEGAL_DONE(1'b1)) dut (
        .clock(clock), .reset(reset), .run(run), .DIN(DIN), .g_nonzero(g_nonzero),
        .r_out(r_out), .g_out(g_out), .DIN_out(DIN_out), .r_in(r_in),
        .a_load(a_load), .g_load(g_load), .add_sub(add_sub), .done(done)
    );

    proc_control_fsm #(.ILLEGAL_DONE(1'b0)) dut_quiet (
        .clock(clock), .reset(reset), .run(run), .DIN(DIN), .g_nonzero(g_nonzero),
        .r_out(q_r_out), .g_out(q_g_out), .DIN_out(q_DIN_out), .r_in(q_r_in),
        .a_load(q_a_load), .g_load(q_g_load), .add_sub(q_add_sub), .done(q_done)
    );

    always #5 clock = ~clock;

    function automatic logic [22:0] mk(input logic [7:0] ro, input logic go, input logic di,
                                       input logic [7:0] ri, input logic al, input logic gl,
                                       input logic asb, input logic dn);
        return {ro, go, di, ri, al, gl, asb, dn};
    endfunction

    task automatic addRow(input logic rst, input logic rn, input logic [8:0] din,
                          input logic gnz, input logic [22:0] exp, input logic illegal,
                          input string name);
        vec_t v;
        v.rst = rst; v.run = rn; v.din = din; v.gnz = gnz;
        v.exp = exp; v.illegal = illegal; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic checkOutput();
        sb_t e;
        logic [22:0] got_main, got_quiet;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty got=0 entries required>=1");
            return;
        end
        e = sb.pop_front();
        got_main  = {r_out, g_out, DIN_out, r_in, a_load, g_load, add_sub, done};
        got_quiet = {q_r_out, q_g_out, q_DIN_out, q_r_in, q_a_load, q_g_load, q_add_sub, q_done};
        checks++;
        if (got_main !== e.exp_main) begin
            failures++;
            $display("[TB] FAIL %s got=%h required=%h", e.name, got_main, e.exp_main);
        end
        checks++;
        if (got_quiet !== e.exp_quiet) begin
            failures++;
            $display("[TB] FAIL %s(quiet) got=%h required=%h", e.name, got_quiet, e.exp_quiet);
        end
        checks++;
        if (!$onehot0(r_out) || ((r_out != 8'h00) && (g_out || DIN_out)) || (g_out && DIN_out)) begin
            failures++;
            $display("[TB] FAIL %s(bus_exclusive) got r_out=%h g_out=%b DIN_out=%b required single source",
                     e.name, r_out, g_out, DIN_out);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rn, input logic [8:0] din,
                                 input logic gnz, input logic [22:0] exp, input logic illegal,
                                 input string name);
        sb_t e;
        @(negedge clock);
        reset = rst;
        run = rn;
        DIN = din;
        g_nonzero = gnz;
        e.exp_main  = exp;
        e.exp_quiet = illegal ? (exp & ~23'd1) : exp;
        e.name      = name;
        sb.push_back(e);
        #2;
        checkOutput();
    endtask

    localparam logic [22:0] ZERO = 23'd0;
    localparam logic [8:0] MVI_R2    = 9'b001_010_000;
    localparam logic [8:0] MV_R5_R3  = 9'b000_101_011;
    localparam logic [8:0] SUB_R1_R6 = 9'b011_001_110;
    localparam logic [8:0] ADD_R3_R3 = 9'b010_011_011;
    localparam logic [8:0] ILL_111   = 9'b111_000_000;
    localparam logic [8:0] MVNZ_R0_R7 = 9'b100_000_111;

    initial begin
        logic mvnz_illegal;
        logic [22:0] mvnz_z_exp, mvnz_nz_exp;
`ifdef CTRL_MVNZ_EN
        mvnz_illegal = 1'b0;
        mvnz_z_exp   = mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
        mvnz_nz_exp  = mk(8'h80, 0, 0, 8'h01, 0, 0, 0, 1);
`else
        mvnz_illegal = 1'b1;
        mvnz_z_exp   = mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
        mvnz_nz_exp  = mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
`endif

        addRow(1, 1, MVI_R2, 0, ZERO, 0, "reset0");
        addRow(1, 0, 9'h000, 0, ZERO, 0, "reset1");
        for (int i = 0; i < 5; i++)
            addRow(0, 0, 9'h1FF, 1, ZERO, 0, "idle");
        addRow(0, 1, MVI_R2, 0, ZERO, 0, "mvi_fetch");
        addRow(0, 0, 9'h000, 0, mk(8'h00, 0, 1, 8'h04, 0, 0, 0, 1), 0, "mvi_T1");
        addRow(0, 1, MV_R5_R3, 0, ZERO, 0, "mv_fetch");
        addRow(0, 1, SUB_R1_R6, 0, mk(8'h08, 0, 0, 8'h20, 0, 0, 0, 1), 0, "mv_T1");
        addRow(0, 1, SUB_R1_R6, 0, ZERO, 0, "sub_fetch");
        addRow(0, 1, MVI_R2, 0, mk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0), 0, "sub_T1");
        addRow(0, 1, MVI_R2, 0, mk(8'h40, 0, 0, 8'h00, 0, 1, 1, 0), 0, "sub_T2");
        addRow(0, 1, ADD_R3_R3, 0, mk(8'h00, 1, 0, 8'h02, 0, 0, 0, 1), 0, "sub_T3");
        addRow(0, 1, ADD_R3_R3, 0, ZERO, 0, "add_fetch");
        addRow(0, 0, 9'h000, 0, mk(8'h08, 0, 0, 8'h00, 1, 0, 0, 0), 0, "add_T1");
        addRow(0, 0, 9'h000, 0, mk(8'h08, 0, 0, 8'h00, 0, 1, 0, 0), 0, "add_T2");
        addRow(0, 0, 9'h000, 0, mk(8'h00, 1, 0, 8'h08, 0, 0, 0, 1), 0, "add_T3");
        addRow(0, 1, ILL_111, 0, ZERO, 0, "ill_fetch");
        addRow(0, 0, 9'h000, 0, mk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1), 1, "ill_T1");
        addRow(0, 0, 9'h000, 0, ZERO, 0, "ill_back_T0");
        addRow(0, 1, MVNZ_R0_R7, 0, ZERO, 0, "mvnz_fetch_z");
        addRow(0, 0, 9'h000, 0, mvnz_z_exp, mvnz_illegal, "mvnz_T1_z");
        addRow(0, 1, MVNZ_R0_R7, 1, ZERO, 0, "mvnz_fetch_nz");
        addRow(0, 0, 9'h000, 1, mvnz_nz_exp, mvnz_illegal, "mvnz_T1_nz");
        addRow(0, 0, 9'h000, 0, ZERO, 0, "mvnz_back_T0");

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].din, vecs[i].gnz,
                          vecs[i].exp, vecs[i].illegal, vecs[i].name);

        // Reset lands in T2 of add R1,R2: outputs must drop at once and G never drives.
        applyStimulus(0, 1, 9'b010_001_010, 0, ZERO, 0, "rst_add_fetch");
        applyStimulus(0, 0, 9'h000, 0, mk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0), 0, "rst_add_T1");
        applyStimulus(1, 0, 9'h000, 0, ZERO, 0, "rst_in_T2");
        applyStimulus(0, 0, 9'h000, 0, ZERO, 0, "rst_after_T0");
        applyStimulus(0, 0, 9'h000, 0, ZERO, 0, "rst_after_idle");
        applyStimulus(0, 1, 9'b001_111_000, 0, ZERO, 0, "rst_mvi_fetch");
        applyStimulus(0, 0, 9'h000, 0, mk(8'h00, 0, 1, 8'h80, 0, 0, 0, 1), 0, "rst_mvi_T1");

        // Reset during T1 of mv must suppress the write and the done pulse.
        applyStimulus(0, 1, 9'b000_110_001, 0, ZERO, 0, "rst_mv_fetch");
        applyStimulus(1, 1, 9'b000_110_001, 0, ZERO, 0, "rst_in_mv_T1");
        applyStimulus(0, 0, 9'h000, 0, ZERO, 0, "rst_mv_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Control sequencer for the nine-bit processor datapath.
- Captures a 9-bit instruction from DIN into an internal IR when run is asserted.
- Steps it through T0..T3, driving the bus-mux source selects (r_out, g_out, DIN_out), the register/A/G load enables and the ALU add/sub select.
- Pulses done on the last cycle of each instruction. Sits beside the bus mux and register file in the processor top level.

Parameters:
ILLEGAL_DONE, 1, 1: undefined opcodes complete in T1 with done=1 and no transfers; 0: undefined opcodes return to T0 silently with done=0.

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  start request; sampled only in T0
DIN  input  9  instruction word, format IIIXXXYYY (III opcode, XXX dest Rx, YYY src Ry)
g_nonzero  input  1  G register != 0 (used only with CTRL_MVNZ_EN)
r_out  output  8  one-hot register-to-bus select (bit n = Rn)
g_out  output  1  G drives bus
DIN_out  output  1  DIN drives bus
r_in  output  8  one-hot register load enable
a_load  output  1  load A from bus
g_load  output  1  load G from ALU
add_sub  output  1  0 = add, 1 = subtract
done  output  1  instruction complete (single-cycle pulse)

Behaviour:
- State and IR:
  - States T0, T1, T2, T3, 2-bit encoded. IR is 9 bits.
  - Reset (synchronous): state=T0, IR=0.
  - All outputs are combinational from state+IR, forced to 0 while reset=1.
  - In T0 with no run, all outputs are 0.
- At most one bus source per cycle: r_out is zero or one-hot, never together with g_out or DIN_out.
- T0: if run=1, IR<=DIN and go to T1; else stay. No outputs asserted.
- T1:
  - 000 mv: r_out=1<<Y, r_in=1<<X, done=1, go to T0.
  - 001 mvi: DIN_out=1, r_in=1<<X, done=1, go to T0. Immediate is taken from DIN in this cycle.
  - 010 add / 011 sub: r_out=1<<X, a_load=1, go to T2.
  - Other opcodes: see ILLEGAL_DONE; go to T0.
- T2 (add/sub only): r_out=1<<Y, g_load=1, add_sub=(opcode==011), go to T3.
- T3: g_out=1, r_in=1<<X, done=1, go to T0.
- Latency from the run-sampling edge:
  - mv/mvi: done in the next cycle (2 cycles incl. fetch).
  - add/sub: done in the 3rd cycle after fetch (4 cycles total).
- run is ignored in T1..T3. With run held high, the next instruction is captured in the T0 cycle immediately after done: back-to-back, one idle-less fetch cycle between instructions.
- X==Y is legal. E.g. add R3,R3: A<=R3, G<=A+R3, R3<=G.
- Reset mid-instruction: the next edge returns to T0 and clears IR. Outputs are gated low during the reset cycle, so there is no partial write in that cycle and done does not assert.
- Unused states are unreachable. Any out-of-range encoding goes to T0.

Optional Feature:
- Macro CTRL_MVNZ_EN.
- Defined: opcode 100 = mvnz Rx,Ry. In T1:
  - if g_nonzero=1: r_out=1<<Y, r_in=1<<X.
  - else: no transfer.
  - Always done=1, go to T0.
- Undefined: opcode 100 is treated as illegal per ILLEGAL_DONE; the g_nonzero input is unused.

Test Plan:
- Reset high 2 cycles, then low: all outputs 0, state T0. With run=0 for 5 cycles, outputs stay 0 and done never pulses.
- run=1, DIN=9'b001_010_000 (mvi R2) at edge 1: next cycle DIN_out=1, r_in=8'h04, done=1, r_out=0, g_out=0. Cycle after: back in T0.
- DIN=9'b000_101_011 (mv R5,R3): T1 r_out=8'h08, r_in=8'h20, done=1.
- DIN=9'b011_001_110 (sub R1,R6):
  - T1: r_out=8'h02, a_load=1.
  - T2: r_out=8'h40, g_load=1, add_sub=1.
  - T3: g_out=1, r_in=8'h02, done=1.
  - Total 4 cycles.
- Assert reset during T2 of an add: the next cycle is T0 with all outputs 0, g_out never asserts, no done. A subsequent mvi executes normally.
- CTRL_MVNZ_EN defined, DIN=9'b100_000_111:
  - g_nonzero=0: T1 r_in=0, r_out=0, done=1.
  - g_nonzero=1: r_out=8'h80, r_in=8'h01, done=1.
  - Macro undefined with ILLEGAL_DONE=0: done=0 and return to T0.
